// File: rtl/noc_params.sv
// Shared NoC types and link-buffer defaults.
// VC_NUM must be a power of two so VC indices wrap naturally.
package noc_params;
  localparam int VC_NUM           = 4;
  localparam int VC_SIZE          = $clog2(VC_NUM);
  localparam int DATA_W           = 16;
  localparam int LINK_BUFFER_SIZE = 8;
  localparam int LINK_OFF_MARGIN  = 3;
  localparam int LINK_ON_HYST     = 1;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef struct packed {
    flit_label_t        flit_label;
    logic [VC_SIZE-1:0] vc_id;
    logic [DATA_W-1:0]  data;
  } flit_t;
endpackage

// File: rtl/router2router.sv
// Router-to-router link: flit forward path plus per-VC on/off and allocatable back path.
interface router2router;
  import noc_params::*;
  flit_t              data;
  logic               is_valid;
  logic [VC_NUM-1:0]  is_on_off;
  logic [VC_NUM-1:0]  is_allocatable;

  modport upstream (output data, is_valid, input is_on_off, is_allocatable);
  modport downstream (input data, is_valid, output is_on_off, is_allocatable);
endinterface

// File: rtl/link_vc_fifo.sv
// Single-VC circular flit buffer with occupancy and a hysteresis on/off flag.
module link_vc_fifo
  import noc_params::*;
#(
  parameter int DEPTH      = 8,
  parameter int OFF_MARGIN = 3,
  parameter int ON_HYST    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  flit_t                  din,
  output flit_t                  head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] occ_next,
  output logic                   on_off,
  output logic                   accepted,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [AW:0] FULL_LVL = OW'(DEPTH);
  localparam logic [AW:0] OFF_LVL  = OW'(DEPTH - OFF_MARGIN);
  localparam logic [AW:0] ON_LVL   = OW'(DEPTH - OFF_MARGIN - ON_HYST);

  flit_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    occ;
  logic           full;

  assign empty    = (occ == '0);
  assign full     = (occ == FULL_LVL);
  // a pop in the same cycle frees the slot, so a full queue can still take the push
  assign accepted = push && (!full || pop);
  assign overflow = push && full && !pop;
  assign head     = mem[rd_ptr];

  always_comb begin
    occ_next = occ;
    if (accepted && !pop)      occ_next = occ + 1'b1;
    else if (!accepted && pop) occ_next = occ - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      on_off <= 1'b1;
    end else begin
      if (accepted) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      occ <= occ_next;
      if (occ_next >= OFF_LVL)     on_off <= 1'b0;
      else if (occ_next <= ON_LVL) on_off <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accepted) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/chiplet_link_buffer.sv
// Per-VC link buffer between chiplets: buffers flits per VC with on/off backpressure
// and forwards one flit per cycle chosen round-robin among eligible VCs.
module chiplet_link_buffer
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = LINK_BUFFER_SIZE,
  parameter int OFF_MARGIN  = LINK_OFF_MARGIN,
  parameter int ON_HYST     = LINK_ON_HYST
) (
  input  logic                clk,
  input  logic                rst,
  router2router.downstream    in_port,
  router2router.upstream      out_port,
  output logic                overflow_err
);
  localparam int OW = $clog2(BUFFER_SIZE) + 1;

  logic [VC_NUM-1:0]  push;
  logic [VC_NUM-1:0]  pop;
  logic [VC_NUM-1:0]  empty;
  logic [VC_NUM-1:0]  on_off;
  logic [VC_NUM-1:0]  accepted;
  logic [VC_NUM-1:0]  ovf;
  logic [VC_NUM-1:0]  eligible;
  logic [VC_NUM-1:0]  open_q;
  logic [VC_NUM-1:0]  open_next;
  logic [VC_NUM-1:0]  alloc_q;
  logic [VC_NUM-1:0]  alloc_next;
  flit_t              head [VC_NUM];
  logic [OW-1:0]      occ_next [VC_NUM];

  logic [VC_SIZE-1:0] rr_ptr;
  logic [VC_SIZE-1:0] winner;
  logic [VC_SIZE-1:0] idx;
  logic               found;
  flit_t              out_data;
  logic               out_valid;
  logic               unused_alloc;

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    assign push[v] = in_port.is_valid && (in_port.data.vc_id == VC_SIZE'(v));

    link_vc_fifo #(
      .DEPTH      (BUFFER_SIZE),
      .OFF_MARGIN (OFF_MARGIN),
      .ON_HYST    (ON_HYST)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[v]),
      .pop      (pop[v]),
      .din      (in_port.data),
      .head     (head[v]),
      .empty    (empty[v]),
      .occ_next (occ_next[v]),
      .on_off   (on_off[v]),
      .accepted (accepted[v]),
      .overflow (ovf[v])
    );
  end

  assign eligible = ~empty & out_port.is_on_off;

  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    idx    = '0;
    pop    = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      idx = rr_ptr + VC_SIZE'(i);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    if (found) pop[winner] = 1'b1;
  end

  // popping a tail closes before a same-cycle head on that VC reopens it
  always_comb begin
    open_next  = open_q;
    alloc_next = '1;
    for (int v = 0; v < VC_NUM; v++) begin
      if (pop[v] && (head[v].flit_label inside {TAIL, HEADTAIL})) open_next[v] = 1'b0;
      if (accepted[v] && (in_port.data.flit_label inside {HEAD, HEADTAIL})) open_next[v] = 1'b1;
      alloc_next[v] = (occ_next[v] == '0) && !open_next[v];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      open_q       <= '0;
      alloc_q      <= '1;
      overflow_err <= 1'b0;
    end else begin
      out_valid <= found;
      if (found) begin
        out_data <= head[winner];
        rr_ptr   <= winner + 1'b1;
      end
      open_q       <= open_next;
      alloc_q      <= alloc_next;
      overflow_err <= overflow_err | (|ovf);
    end
  end

  assign out_port.data          = out_data;
  assign out_port.is_valid      = out_valid;
  assign in_port.is_on_off      = on_off;
  assign in_port.is_allocatable = alloc_q;
  assign unused_alloc           = ^out_port.is_allocatable;
endmodule

// File: tb/tb_chiplet_link_buffer.sv
// Directed and random checks of chiplet_link_buffer against a queue-based reference model.
module tb_chiplet_link_buffer;
  import noc_params::*;

  localparam int BS = LINK_BUFFER_SIZE;
  localparam int OM = LINK_OFF_MARGIN;
  localparam int HY = LINK_ON_HYST;

  logic clk = 1'b0;
  logic rst;
  logic overflow_err;
  logic [VC_NUM-1:0] dn_on;

  router2router in_if ();
  router2router out_if ();

  chiplet_link_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .in_port      (in_if),
    .out_port     (out_if),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  flit_t mq [VC_NUM][$];
  bit    m_on [VC_NUM];
  bit    m_open [VC_NUM];
  int    m_rr;
  bit    m_valid;
  flit_t m_data;
  bit    m_ovf;

  function automatic flit_t mk(input int vc, input flit_label_t lab, input int pay);
    flit_t f;
    f.flit_label = lab;
    f.vc_id      = VC_SIZE'(vc);
    f.data       = DATA_W'(pay);
    return f;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int v = 0; v < VC_NUM; v++) begin
      mq[v].delete();
      m_on[v]   = 1'b1;
      m_open[v] = 1'b0;
    end
    m_rr    = 0;
    m_valid = 1'b0;
    m_data  = '0;
    m_ovf   = 1'b0;
  endfunction

  function automatic logic [VC_NUM-1:0] m_on_vec();
    logic [VC_NUM-1:0] r;
    for (int v = 0; v < VC_NUM; v++) r[v] = m_on[v];
    return r;
  endfunction

  function automatic logic [VC_NUM-1:0] m_alloc_vec();
    logic [VC_NUM-1:0] r;
    for (int v = 0; v < VC_NUM; v++) r[v] = (mq[v].size() == 0) && !m_open[v];
    return r;
  endfunction

  function automatic int m_total();
    int t = 0;
    for (int v = 0; v < VC_NUM; v++) t += mq[v].size();
    return t;
  endfunction

  // One clock edge of the reference: pop first, then push, then flow-control flags.
  function automatic void model_edge(input bit vld, input flit_t f, input logic [VC_NUM-1:0] dn);
    int win = -1;
    for (int k = 0; k < VC_NUM; k++) begin
      int v = (m_rr + k) % VC_NUM;
      if (win < 0 && mq[v].size() > 0 && dn[v]) win = v;
    end
    if (win >= 0) begin
      flit_t p = mq[win].pop_front();
      m_valid = 1'b1;
      m_data  = p;
      m_rr    = (win + 1) % VC_NUM;
      if (p.flit_label == TAIL || p.flit_label == HEADTAIL) m_open[win] = 1'b0;
    end else begin
      m_valid = 1'b0;
    end
    if (vld) begin
      int v = int'(f.vc_id);
      if (mq[v].size() < BS) begin
        mq[v].push_back(f);
        if (f.flit_label == HEAD || f.flit_label == HEADTAIL) m_open[v] = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    for (int v = 0; v < VC_NUM; v++) begin
      if (mq[v].size() >= BS - OM)         m_on[v] = 1'b0;
      else if (mq[v].size() <= BS - OM - HY) m_on[v] = 1'b1;
    end
  endfunction

  task automatic compare_all();
    check("out_valid", out_if.is_valid, m_valid);
    if (m_valid) check("out_data", out_if.data, m_data);
    check("in_on_off", in_if.is_on_off, m_on_vec());
    check("in_alloc", in_if.is_allocatable, m_alloc_vec());
    check("overflow_err", overflow_err, m_ovf);
  endtask

  task automatic cycle(input bit vld, input flit_t f);
    in_if.is_valid   = vld;
    in_if.data       = vld ? f : '0;
    out_if.is_on_off = dn_on;
    model_edge(vld, f, dn_on);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drain();
    dn_on = '1;
    for (int k = 0; k < 80 && m_total() > 0; k++) cycle(1'b0, '0);
    cycle(1'b0, '0);
    check("drained", m_total(), 0);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    in_if.is_valid = 1'b0;
    in_if.data     = '0;
    repeat (2) @(negedge clk);
    m_reset();
    check("rst_on_off", in_if.is_on_off, {VC_NUM{1'b1}});
    check("rst_alloc", in_if.is_allocatable, {VC_NUM{1'b1}});
    check("rst_out_valid", out_if.is_valid, 1'b0);
    check("rst_out_data", out_if.data, 0);
    check("rst_overflow", overflow_err, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    flit_t f;
    in_if.is_valid        = 1'b0;
    in_if.data            = '0;
    out_if.is_on_off      = '1;
    out_if.is_allocatable = '0;
    dn_on                 = '1;
    do_reset();

    // single HEADTAIL, minimum latency
    dn_on = '1;
    f = mk(0, HEADTAIL, 16'hA5A5);
    cycle(1'b1, f);
    check("ht_alloc_busy", in_if.is_allocatable[0], 1'b0);
    check("ht_not_yet_out", out_if.is_valid, 1'b0);
    cycle(1'b0, '0);
    check("ht_out_valid", out_if.is_valid, 1'b1);
    check("ht_out_data", out_if.data, f);
    check("ht_alloc_free", in_if.is_allocatable[0], 1'b1);
    cycle(1'b0, '0);

    // VC1 held off: on/off drops at occupancy 5, returns at 4
    dn_on = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, mk(1, (i == 0) ? HEAD : ((i == 4) ? TAIL : BODY), 16'h100 + i));
      if (i == 3) check("vc1_on_at4", in_if.is_on_off[1], 1'b1);
      if (i == 4) check("vc1_off_at5", in_if.is_on_off[1], 1'b0);
    end
    dn_on = '1;
    cycle(1'b0, '0);
    check("vc1_on_after_pop", in_if.is_on_off[1], 1'b1);
    drain();

    // interleave VC0 and VC1 after preloading both
    dn_on = '0;
    for (int i = 0; i < 6; i++) cycle(1'b1, mk(i % 2, BODY, 16'h200 + i));
    dn_on = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, '0);
      check("alt_vc", out_if.data.vc_id, i % 2);
      check("alt_payload", out_if.data.data, 16'h200 + i);
    end
    drain();

    // overflow on VC2
    dn_on = '0;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, mk(2, BODY, 16'h300 + i));
      if (i == 7) check("vc2_no_ovf_at8", overflow_err, 1'b0);
    end
    check("vc2_ovf_set", overflow_err, 1'b1);
    drain();
    check("vc2_ovf_sticky", overflow_err, 1'b1);

    // full VC3 with simultaneous push and pop
    do_reset();
    dn_on = '0;
    for (int i = 0; i < 8; i++) cycle(1'b1, mk(3, BODY, 16'h400 + i));
    dn_on = 4'b1000;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, mk(3, BODY, 16'h500 + i));
      check("vc3_fifo_order", out_if.data.data, 16'h400 + i);
      check("vc3_still_off", in_if.is_on_off[3], 1'b0);
      check("vc3_no_ovf", overflow_err, 1'b0);
    end
    drain();

    // random traffic, mostly honouring on/off
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int vc;
      bit vld;
      dn_on = VC_NUM'($urandom);
      vc    = int'($urandom_range(0, VC_NUM - 1));
      vld   = ($urandom_range(0, 3) != 0) && (m_on[vc] || $urandom_range(0, 15) == 0);
      if (n == 300) begin
        do_reset();
      end
      cycle(vld, mk(vc, flit_label_t'($urandom_range(0, 3)), int'($urandom_range(0, 16'hFFFF))));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
